// File: rtl/stack_sequencer_pkg.sv
// stack_sequencer_pkg: shared state encoding, mux segment codes and SP defaults
package stack_sequencer_pkg;
   typedef enum logic [2:0] {
      IDLE, PUSH_H, PUSH_L, PUSH_F, POP_F, POP_L, POP_H, POP_FIN
   } state_t;
   localparam logic [1:0] SEG_PC_H  = 2'b00;
   localparam logic [1:0] SEG_PC_L  = 2'b01;
   localparam logic [1:0] SEG_FLAGS = 2'b10;
   localparam int ADDR_W_DEF = 12;
   function automatic int sp_top(input int w);
      return 2**w - 1;
   endfunction
endpackage

// File: rtl/stack_sequencer_stack_pointer.sv
// stack_pointer: SP register with inc/dec and a combinational SP+1 for pop addressing
module stack_pointer #(
   parameter int ADDR_W = 12,
   parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              dec,
   output logic [ADDR_W-1:0] sp,
   output logic [ADDR_W-1:0] sp_inc
);
   assign sp_inc = sp + ADDR_W'(1);
   always_ff @(posedge clk or posedge rst)
      if (rst) sp <= SP_INIT;
      else if (inc) sp <= sp_inc;
      else if (dec) sp <= sp - ADDR_W'(1);
endmodule

// File: rtl/stack_sequencer.sv
// stack_sequencer: sequences multi-word CALL/INT pushes and RET/RTI pops, owns SP
module stack_sequencer
   import stack_sequencer_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] SP_INIT = ADDR_W'(sp_top(ADDR_W))
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              call_req,
   input  logic              int_req,
   input  logic              ret_req,
   input  logic              rti_req,
   input  logic              push_req,
   input  logic              pop_req,
   input  logic [15:0]       mem_rdata,
   output logic              pc_to_stack,
   output logic [1:0]        pc_segment,
   output logic              mem_write,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              stall,
   output logic [ADDR_W-1:0] sp_out,
   output logic [31:0]       pc_out,
   output logic              pc_load,
   output logic [2:0]        flags_out,
   output logic              flags_load
);
   state_t state, next_state;
   logic with_flags, multi;
   logic [ADDR_W-1:0] sp, sp_p1;

   stack_pointer #(.ADDR_W(ADDR_W), .SP_INIT(SP_INIT)) u_sp (
      .clk(clk), .rst(rst), .inc(mem_read), .dec(mem_write), .sp(sp), .sp_inc(sp_p1)
   );

   assign sp_out = sp;
   assign multi = int_req | rti_req | call_req | ret_req;
   assign mem_addr = mem_write ? sp : mem_read ? sp_p1 : '0;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= next_state;

   always_comb begin
      next_state = IDLE;
      case (state)
         IDLE:    next_state = int_req ? PUSH_H : rti_req ? POP_F : call_req ? PUSH_H :
                               ret_req ? POP_L : IDLE;
         PUSH_H:  next_state = PUSH_L;
         PUSH_L:  next_state = with_flags ? PUSH_F : IDLE;
         POP_F:   next_state = POP_L;
         POP_L:   next_state = POP_H;
         POP_H:   next_state = POP_FIN;
         default: next_state = IDLE;
      endcase
   end

   // Only IDLE looks at the request lines; every other state is a pure decode.
   always_comb begin
      mem_write = 1'b0;
      mem_read = 1'b0;
      pc_to_stack = 1'b0;
      pc_segment = SEG_PC_H;
      stall = 1'b0;
      case (state)
         IDLE: begin
            stall = !rst && multi;
            mem_write = !rst && !multi && push_req;
            mem_read = !rst && !multi && !push_req && pop_req;
         end
         PUSH_H: {mem_write, pc_to_stack, pc_segment, stall} = {2'b11, SEG_PC_H, 1'b1};
         PUSH_L: {mem_write, pc_to_stack, pc_segment, stall} = {2'b11, SEG_PC_L, with_flags};
         PUSH_F: {mem_write, pc_to_stack, pc_segment} = {2'b11, SEG_FLAGS};
         POP_F, POP_L, POP_H: {mem_read, stall} = 2'b11;
         default: ;
      endcase
   end

   // Load pulses are registered so they coincide with the captured values.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         with_flags <= 1'b0;
         pc_out <= '0;
         flags_out <= '0;
         pc_load <= 1'b0;
         flags_load <= 1'b0;
      end else begin
         pc_load <= state == POP_FIN;
         flags_load <= state == POP_L && with_flags;
         if (state == IDLE) with_flags <= int_req | rti_req;
         if (state == POP_L && with_flags) flags_out <= mem_rdata[2:0];
         if (state == POP_H) pc_out[15:0] <= mem_rdata;
         if (state == POP_FIN) pc_out[31:16] <= mem_rdata;
      end
endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Memory-stage controller directly upstream of the memory-data select mux.
- Drives `pc_to_stack` and `pc_segment` (00 = PC high, 01 = PC low, 10 = flags) and owns the stack pointer.
- Sequences the multi-cycle stack traffic for CALL/INT pushes and RET/RTI pops, and the single-word PUSH/POP.
- Stalls the pipeline while a multi-word sequence runs, then reassembles the popped PC and flags for the fetch stage.

Parameters:
- ADDR_W, 12, data-memory word-address width; SP is ADDR_W bits.
- SP_INIT, 2**ADDR_W-1, stack pointer value after reset (top of memory; stack grows down).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- call_req  in  1  CALL in memory stage: push PC_H, PC_L.
- int_req  in  1  INT in memory stage: push PC_H, PC_L, flags.
- ret_req  in  1  RET: pop PC_L, PC_H.
- rti_req  in  1  RTI: pop flags, PC_L, PC_H.
- push_req  in  1  single-word PUSH of the ALU value.
- pop_req  in  1  single-word POP.
- mem_rdata  in  16  data-memory read data; valid the cycle after `mem_read`.
- pc_to_stack  out  1  1 = mux selects PC/flags source.
- pc_segment  out  2  mux segment select.
- mem_write  out  1  write strobe.
- mem_read  out  1  read strobe.
- mem_addr  out  ADDR_W  memory word address.
- stall  out  1  hold memory stage and upstream stages.
- sp_out  out  ADDR_W  current SP.
- pc_out  out  32  popped PC {H,L}.
- pc_load  out  1  one-cycle pulse; `pc_out` valid.
- flags_out  out  3  popped flags (`mem_rdata[2:0]`).
- flags_load  out  1  one-cycle pulse; `flags_out` valid.

Behaviour:
- **Reset (async, any state, including mid-sequence):**
  - state = IDLE; SP = SP_INIT; pc_out = 0; flags_out = 0.
  - All strobes, `stall`, `pc_to_stack` and `pc_segment` = 0.
  - Any partial sequence is abandoned; no further writes.
- **States:** IDLE, PUSH_H, PUSH_L, PUSH_F, POP_F, POP_L, POP_H, POP_FIN.
- **Request sampling:** requests are sampled only in IDLE and ignored elsewhere. Priority: int > rti > call > ret > push > pop.
- **Push addressing:** write at SP, then SP <= SP-1 on the same edge.
- **Pop addressing:** read at SP+1, then SP <= SP+1 on the same edge.
- **SP wrap:** arithmetic is modulo 2**ADDR_W; wrap is silent, no error flag.
- **IDLE + push_req:** mem_write=1, addr=SP, pc_to_stack=0, stall=0; one cycle, no state change.
- **IDLE + pop_req:** mem_read=1, addr=SP+1, stall=0; data goes to writeback on the normal path.
- **IDLE + multi-word request:** stall=1 combinationally, no memory op; next state:
  - PUSH_H for call/int;
  - POP_F for rti;
  - POP_L for ret.
- **PUSH_H:** write, pc_to_stack=1, seg=00, stall=1 -> PUSH_L.
- **PUSH_L:** write, seg=01.
  - CALL: stall=0 (last cycle) -> IDLE.
  - INT: stall=1 -> PUSH_F.
- **PUSH_F:** write, seg=10, stall=0 -> IDLE.
- **POP_F:** read, stall=1 -> POP_L.
- **POP_L:** read, stall=1.
  - If previous state was POP_F: capture `flags_out` from `mem_rdata`, pulse flags_load.
  - -> POP_H.
- **POP_H:** read, stall=1; capture `mem_rdata` into pc_out[15:0] -> POP_FIN.
- **POP_FIN:** no memory op; capture `mem_rdata` into pc_out[31:16]; pc_load=1; stall=0 -> IDLE.
- **Cycle counts from request acceptance to stall release:** CALL 3, INT 4, RET 4, RTI 5.
- **Output timing:** memory controls are Moore decodes of state, except the IDLE single-word path. `pc_out` and `flags_out` are registered and hold until the next pop sequence.
- **Exit cycle:** `stall` is 0 in the final cycle, so the instruction advances. The IDLE state on the next cycle therefore sees the next instruction, never a re-trigger.

Decomposition:
- Shared package holds:
  - state encoding;
  - segment constants SEG_PC_H=2'b00, SEG_PC_L=2'b01, SEG_FLAGS=2'b10;
  - SP_INIT default.
- One sub-module, `stack_pointer`: SP register with async reset, inc/dec controls, and a combinational SP+1 output.

Test Plan:
- Reset mid-INT at PUSH_L -> all outputs 0, sp_out=12'hFFF next cycle; an immediate int_req restarts cleanly at PUSH_H.
- call_req, SP=0xFFF -> writes addr 0xFFF seg00, addr 0xFFE seg01; stall pattern 1,1,0; sp_out=0xFFD.
- int_req, SP=0x100 -> writes 0x100/0x0FF/0x0FE with seg 00/01/10 and pc_to_stack=1; stall 1,1,1,0; SP=0x0FD.
- rti_req after that INT, memory holding 0x0005 flags, L=0xBEEF, H=0x0012 -> flags_out=3'b101 pulse, then pc_out=0x0012BEEF with pc_load; SP=0x100.
- push_req at SP=0x000 then pop_req -> write addr 0x000, SP wraps to 0xFFF; pop reads 0x000; no stall either cycle.
- int_req and push_req together -> INT sequence only; push ignored until IDLE.
